// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-FF synchronise and debounce raw slide switches, with edge strobes
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0]            deb_q, deb_d, rise_q, rise_d, fall_q, fall_d;
    logic                        chg_q, chg_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Per-bit stability count; a bit is accepted only after the terminal count, any return to the accepted level restarts it
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d = deb_d & ~deb_q;
        fall_d = ~deb_d & deb_q;
        chg_d  = |(deb_d ^ deb_q);
    end

    // All state, including the strobes, is registered so outputs come straight from flops
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            chg_q   <= chg_d;
        end
    end

    assign sw_debounced = deb_q;
    assign sw_rise      = rise_q;
    assign sw_fall      = fall_q;
    assign sw_changed   = chg_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed checks of switch_debouncer with STABLE_CYCLES=4
module tb_switch_debouncer;
    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic [7:0] sw_debounced, sw_rise, sw_fall;
    logic       sw_changed;
    int         n_chk = 0;
    int         n_fail = 0;

    switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .sw_raw(sw_raw),
        .sw_debounced(sw_debounced),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] deb, input logic [7:0] rise,
                           input logic [7:0] fall, input logic chg);
        chk({tag, "_deb"}, sw_debounced, deb);
        chk({tag, "_rise"}, sw_rise, rise);
        chk({tag, "_fall"}, sw_fall, fall);
        chk({tag, "_chg"}, {7'b0, sw_changed}, {7'b0, chg});
    endtask

    task automatic quiet(input int n, input logic [7:0] deb, input string tag);
        for (int k = 0; k < n; k++) begin
            step();
            chk_all(tag, deb, 8'h00, 8'h00, 1'b0);
        end
    endtask

    // Called just after sw_raw changes; the next edge is edge 1 and the update must land on edge 6
    task automatic settle(input logic [7:0] cur, input logic [7:0] nxt, input string tag);
        quiet(5, cur, {tag, "_hold"});
        step();
        chk_all({tag, "_upd"}, nxt, nxt & ~cur, cur & ~nxt, cur != nxt);
        quiet(1, nxt, {tag, "_post"});
    endtask

    initial begin
        sw_raw = 8'hFF;
        step();
        step();
        #3 reset_reset = 1'b1;
        #1 chk_all("rst_async", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        chk_all("rst_held", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_reset = 1'b0;
        settle(8'h00, 8'hFF, "powerup");

        sw_raw = 8'h00;
        settle(8'hFF, 8'h00, "all_fall");

        sw_raw = 8'h01;
        settle(8'h00, 8'h01, "clean_rise");
        sw_raw = 8'h00;
        settle(8'h01, 8'h00, "clean_fall");

        sw_raw = 8'h08;
        quiet(3, 8'h00, "glitch_hi");
        sw_raw = 8'h00;
        quiet(10, 8'h00, "glitch_lo");

        sw_raw = 8'h20;
        quiet(1, 8'h00, "bounce");
        sw_raw = 8'h00;
        quiet(1, 8'h00, "bounce");
        sw_raw = 8'h20;
        quiet(1, 8'h00, "bounce");
        sw_raw = 8'h00;
        quiet(1, 8'h00, "bounce");
        sw_raw = 8'h20;
        settle(8'h00, 8'h20, "bounce_final");
        sw_raw = 8'h00;
        settle(8'h20, 8'h00, "bounce_clr");

        sw_raw = 8'hA5;
        settle(8'h00, 8'hA5, "multi_a5");
        sw_raw = 8'h5A;
        settle(8'hA5, 8'h5A, "multi_5a");
        sw_raw = 8'h00;
        settle(8'h5A, 8'h00, "multi_clr");

        sw_raw = 8'h02;
        quiet(4, 8'h00, "midrst_pre");
        reset_reset = 1'b1;
        #1 chk_all("midrst_async", 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        reset_reset = 1'b0;
        settle(8'h00, 8'h02, "midrst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
